// File: rtl/nb_inv.sv
// ============================================================================
// Module   : nb_inv
// Brief    : Bit-serial GF(2^5) normal-basis inverter, Z = A^30 (Itoh-Tsujii).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nb_inv (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] A,
  output logic       busy,
  output logic       done,
  output logic [4:0] Z,
  output logic       zero
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SQ1  = 3'd1;
  localparam logic [2:0] S_MUL1 = 3'd2;
  localparam logic [2:0] S_SQ2  = 3'd3;
  localparam logic [2:0] S_MUL2 = 3'd4;
  localparam logic [2:0] S_SQ3  = 3'd5;

  logic [2:0] r_state;
  logic [2:0] r_cnt;
  logic [4:0] r_x;
  logic [4:0] r_a;
  logic [4:0] r_b;
  logic [4:0] r_acc;
  logic [4:0] r_z;
  logic       r_zero;
  logic       r_busy;
  logic       r_done;

  logic       w_c1, w_c2, w_c3, w_c4;
  logic       w_d0, w_d1, w_d2;
  logic [4:0] w_acc_nxt;

  // One serial step of the normal-basis product on the current (a, b) pair.
  always_comb begin
    w_c1      = r_a[0] ^ r_a[4];
    w_c2      = r_b[0] ^ r_b[4];
    w_c3      = r_a[1] ^ r_a[4];
    w_c4      = r_b[1] ^ r_b[4];
    w_d0      = r_a[4] & r_b[4];
    w_d1      = w_c1 & w_c2;
    w_d2      = w_c3 & w_c4;
    w_acc_nxt = {r_acc[3] ^ w_d2,
                 r_acc[2] ^ w_d1 ^ w_d2,
                 r_acc[1],
                 r_acc[0],
                 r_acc[4] ^ w_d0 ^ w_d1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_x     <= 5'd0;
      r_a     <= 5'd0;
      r_b     <= 5'd0;
      r_acc   <= 5'd0;
      r_z     <= 5'd0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= A;
            r_busy  <= 1'b1;
            r_state <= S_SQ1;
          end
        end
        S_SQ1: begin
          r_a     <= {r_x[3:0], r_x[4]};
          r_b     <= r_x;
          r_acc   <= 5'd0;
          r_cnt   <= 3'd0;
          r_state <= S_MUL1;
        end
        S_MUL1, S_MUL2: begin
          r_acc <= w_acc_nxt;
          r_a   <= {r_a[3:0], r_a[4]};
          r_b   <= {r_b[3:0], r_b[4]};
          if (r_cnt == 3'd4) begin
            r_cnt   <= 3'd0;
            r_state <= (r_state == S_MUL1) ? S_SQ2 : S_SQ3;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_SQ2: begin
          // acc holds A^3; A^12 is a two-place rotation of it.
          r_a     <= {r_acc[2:0], r_acc[4:3]};
          r_b     <= r_acc;
          r_acc   <= 5'd0;
          r_cnt   <= 3'd0;
          r_state <= S_MUL2;
        end
        S_SQ3: begin
          r_z     <= {r_acc[3:0], r_acc[4]};
          r_zero  <= (r_x == 5'd0);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Z    = r_z;
  assign zero = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_nb_inv.sv
// ============================================================================
// Module   : tb_nb_inv
// Brief    : Directed self-checking bench for the nb_inv normal-basis inverter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nb_inv;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] A;
  logic       busy;
  logic       done;
  logic [4:0] Z;
  logic       zero;

  int pass_cnt;
  int total_cnt;

  logic [4:0] zr [32];

  nb_inv dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .busy  (busy),
    .done  (done),
    .Z     (Z),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] m_nbm(input logic [4:0] x, input logic [4:0] y);
    logic [4:0] acc, a, b;
    logic c1, c2, c3, c4, d0, d1, d2;
    acc = 5'd0; a = x; b = y;
    for (int s = 0; s < 5; s++) begin
      c1 = a[0] ^ a[4]; c2 = b[0] ^ b[4];
      c3 = a[1] ^ a[4]; c4 = b[1] ^ b[4];
      d0 = a[4] & b[4]; d1 = c1 & c2; d2 = c3 & c4;
      acc = {acc[3] ^ d2, acc[2] ^ d1 ^ d2, acc[1], acc[0], acc[4] ^ d0 ^ d1};
      a = {a[3:0], a[4]};
      b = {b[3:0], b[4]};
    end
    return acc;
  endfunction

  function automatic logic [4:0] m_sq(input logic [4:0] x);
    return {x[3:0], x[4]};
  endfunction

  // Inverse found by search over the field, independent of the addition chain.
  function automatic logic [4:0] m_inv(input logic [4:0] x);
    logic [4:0] r;
    r = 5'd0;
    for (int z = 1; z < 32; z++)
      if (m_nbm(x, 5'(z)) == 5'b11111) r = 5'(z);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = 5'd0;
    tick(); tick();
    total_cnt++;
    if ({busy, done, zero, Z} !== 8'd0) $display("FAIL reset_state: got %b required 00000000", {busy, done, zero, Z});
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_model();
    logic [4:0] r;
    r = m_nbm(5'b00001, 5'b00001);
    total_cnt++;
    if (r !== 5'b00010) $display("FAIL model_1x1: got %b required 00010", r);
    else pass_cnt++;
    for (int x = 0; x < 32; x++) begin
      r = m_nbm(5'b11111, 5'(x));
      total_cnt++;
      if (r !== 5'(x)) $display("FAIL model_identity x=%0d: got %b required %b", x, r, 5'(x));
      else pass_cnt++;
    end
  endtask

  task automatic test_identity();
    A = 5'b11111; start = 1'b1;
    tick();
    start = 1'b0; A = 5'b00000;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i < 13) begin
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0) $display("FAIL identity_busy cyc=%0d: got busy=%b done=%b required busy=1 done=0", i, busy, done);
        else pass_cnt++;
      end else begin
        total_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || Z !== 5'b11111 || zero !== 1'b0)
          $display("FAIL identity_result: got done=%b busy=%b Z=%b zero=%b required 1 0 11111 0", done, busy, Z, zero);
        else pass_cnt++;
      end
    end
    tick();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL identity_done_pulse: got done=%b required 0", done);
    else pass_cnt++;
  endtask

  task automatic test_exhaustive();
    int n;
    A = 5'd1; start = 1'b1;
    tick();
    n = 0;
    for (int a = 1; a < 32; a++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!done && n < 30);
      if (a < 31) A = 5'(a + 1);
      else start = 1'b0;
      total_cnt++;
      if (n !== ((a == 1) ? 13 : 14)) $display("FAIL exh_spacing a=%0d: got %0d cycles required %0d", a, n, (a == 1) ? 13 : 14);
      else pass_cnt++;
      zr[a] = Z;
      total_cnt++;
      if (Z !== m_inv(5'(a)) || m_nbm(5'(a), Z) !== 5'b11111 || zero !== 1'b0)
        $display("FAIL exh_inverse a=%0d: got Z=%b zero=%b required Z=%b zero=0", a, Z, zero, m_inv(5'(a)));
      else pass_cnt++;
    end
    for (int a = 1; a < 32; a++) begin
      total_cnt++;
      if (zr[m_sq(5'(a))] !== m_sq(zr[a]))
        $display("FAIL exh_sq_commute a=%0d: got %b required %b", a, zr[m_sq(5'(a))], m_sq(zr[a]));
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic run_one(input logic [4:0] av, output int n);
    A = av; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 30);
  endtask

  task automatic test_zero();
    int n;
    run_one(5'b00000, n);
    total_cnt++;
    if (n !== 13 || Z !== 5'b00000 || zero !== 1'b1)
      $display("FAIL zero_operand: got n=%0d Z=%b zero=%b required 13 00000 1", n, Z, zero);
    else pass_cnt++;
    tick();
    run_one(5'b11111, n);
    total_cnt++;
    if (n !== 13 || Z !== 5'b11111 || zero !== 1'b0)
      $display("FAIL zero_clears: got n=%0d Z=%b zero=%b required 13 11111 0", n, Z, zero);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_ignore_busy();
    int dones;
    A = 5'b00001; start = 1'b1;
    tick();
    A = 5'b11111; start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 28; i++) begin
      start = (i == 3 || i == 8);
      tick();
      if (done) dones++;
      if (i < 13) begin
        total_cnt++;
        if (Z !== 5'b11111 || done !== 1'b0 || busy !== 1'b1)
          $display("FAIL ignore_hold cyc=%0d: got Z=%b done=%b busy=%b required 11111 0 1", i, Z, done, busy);
        else pass_cnt++;
      end else if (i == 13) begin
        total_cnt++;
        if (done !== 1'b1 || Z !== m_inv(5'b00001))
          $display("FAIL ignore_result: got done=%b Z=%b required 1 %b", done, Z, m_inv(5'b00001));
        else pass_cnt++;
      end
    end
    start = 1'b0;
    total_cnt++;
    if (dones !== 1) $display("FAIL ignore_done_count: got %0d required 1", dones);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    int n;
    int dones;
    A = 5'b00101; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, zero, Z} !== 8'd0) $display("FAIL rst_midop: got %b required 00000000", {busy, done, zero, Z});
    else pass_cnt++;
    tick(); tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dones++;
    end
    total_cnt++;
    if (dones !== 0 || Z !== 5'd0) $display("FAIL rst_no_done: got dones=%0d Z=%b required 0 00000", dones, Z);
    else pass_cnt++;
    run_one(5'b11111, n);
    total_cnt++;
    if (n !== 13 || Z !== 5'b11111 || zero !== 1'b0)
      $display("FAIL rst_restart: got n=%0d Z=%b zero=%b required 13 11111 0", n, Z, zero);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_model();
    test_identity();
    test_exhaustive();
    test_zero();
    test_ignore_busy();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nb_inv.md
Name: nb_inv

Overview:
- Bit-serial GF(2^5) normal-basis inverter. It is the inverse-direction companion of the team's normal-basis multiplier and uses the same product function and bit ordering.
- It computes Z = A^-1 = A^30 by Itoh-Tsujii: squarings are cyclic rotations, and there are two multiplications on an internal 5-step serial multiplier core.
- It sits beside nb_mult in the field-arithmetic datapath. It feeds division (A*B^-1) and point-arithmetic sequencers.

Parameters:
- None. The field (m=5) and the normal basis are fixed and identical to nb_mult.

Ports:
- clk    input   1  system clock; all state updates on the rising edge
- rst    input   1  asynchronous, active-high reset
- start  input   1  request; sampled only in IDLE
- A      input   5  operand, normal-basis bits [4:0]; captured on the accepting edge
- busy   output  1  high from the accepting edge until the completion edge
- done   output  1  one-cycle pulse when Z is updated
- Z      output  5  result register; holds its value until the next completion
- zero   output  1  registered with Z: 1 when the captured A was 00000

Behaviour:
- Reset: asynchronous, active-high. Interface decided: one clock `clk`; reset `rst` is asynchronous and active-high.
  - Forces state=IDLE, busy=0, done=0, Z=00000, zero=0, internal registers=0.
  - Reset mid-operation aborts the computation. No done is produced for the aborted operation.
- Square: sq(x) = {x[3:0], x[4]} (rotate left 1). This equals nbm(x,x).
- nbm(x,y), 5 serial steps. Set acc=0, a=x, b=y. Each step:
  - c1=a0^a4, c2=b0^b4, c3=a1^a4, c4=b1^b4
  - d0=a4&b4, d1=c1&c2, d2=c3&c4
  - acc <= {acc3^d2, acc2^d1^d2, acc1, acc0, acc4^d0^d1}
  - then a,b rotate left 1
  - After step 5, acc = x*y.
- FSM states: IDLE, SQ1, MUL1, SQ2, MUL2, SQ3.
  - IDLE: start=1 at an edge -> capture x=A, busy<=1, go to SQ1. start=0 -> stay.
  - SQ1 (1 cycle): t = sq(x) = A^2. Load the core with (t, x) and clear acc.
  - MUL1 (5 cycles, step counter 0..4): t = nbm(A^2, A) = A^3.
  - SQ2 (1 cycle): u = rot-left-2(t) = A^12. Load the core with (u, t) and clear acc.
  - MUL2 (5 cycles): t = nbm(A^12, A^3) = A^15.
  - SQ3 (1 cycle): on exit Z <= sq(t) = A^30, zero <= (x==0), done<=1, busy<=0, go to IDLE.
- Latency and throughput:
  - start accepted at edge k -> Z/done valid after edge k+13.
  - done is high exactly one cycle, the IDLE cycle following SQ3.
  - start during that done cycle is accepted at edge k+14, so back-to-back issue is one result per 14 cycles.
- start while busy=1 is ignored; no queueing.
- A changing after the accepting edge has no effect.
- A=00000 produces Z=00000 and zero=1 (no exception state); done still pulses.
- The step counter wraps 4->0 only on the MUL->SQ transition. There are no other counter states.

Test Plan:
- Model sanity: drive the bench nbm model with (00001,00001) -> 00010 and (11111,x) -> x for all 32 x. This confirms the model matches nb_mult.
- Identity: A=11111, start pulse -> done after exactly 13 cycles, Z=11111, zero=0, busy high for 13 cycles.
- Exhaustive: all 31 nonzero A, back-to-back with start held high.
  - nbm(A,Z)=11111 for every A.
  - Spacing between done pulses is 14 cycles.
  - sq-commutation holds: inv(sq(A)) = sq(inv(A)).
- Zero operand: A=00000 -> Z=00000, zero=1, done pulse. A following A=11111 clears zero to 0.
- Ignore while busy:
  - start=1 with A=00001 at edge k, then A=11111 with start pulses at k+3 and k+8 -> one done only, at k+13, with Z=inv(00001).
  - Z is unchanged until then.
- Reset mid-op: assert rst asynchronously during MUL2 (edge k+9) -> busy, done, Z and zero drop to 0 immediately. No done follows, and a new start after rst release completes normally.
